// File: rtl/pipeline_drain_pkg.sv
// rtl/pipeline_drain_pkg.sv - shared widths, entry type and id-match helper for the drain block
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef DRAIN_DEPTH
`define DRAIN_DEPTH 8
`endif

package pipeline_drain_pkg;

   localparam int ADDR_W      = `ADDRESS_WIDTH;
   localparam int ID_W        = `ID_WIDTH;
   localparam int DRAIN_DEPTH = `DRAIN_DEPTH;

   typedef logic [ADDR_W-1:0] address_t;
   typedef logic [ID_W-1:0]   id_t;

   // One buffered pipeline result; address and id pass through untouched.
   typedef struct packed {
      address_t address;
      id_t      id;
   } entry_t;

   // True when a flush is active this edge and targets the given id.
   function automatic logic id_match(input logic en, input id_t a, input id_t b);
      return en && (a == b);
   endfunction

endpackage

// File: rtl/drain_fifo.sv
// rtl/drain_fifo.sv - circular buffer with per-entry live bits and id-match purge
module drain_fifo
   import pipeline_drain_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PTR_W = $clog2(DEPTH)
)
(
   input  logic           clk,
   input  logic           reset_n,
   input  logic           push,
   input  entry_t         push_entry,
   input  logic           pop,
   input  logic           purge,
   input  id_t            purge_id,
   output entry_t         head_entry,
   output logic           head_live,
   output logic [PTR_W:0] occupancy
);

   localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   OCC_ONE = {{PTR_W{1'b0}}, 1'b1};

   entry_t           mem [DEPTH];
   logic [DEPTH-1:0] live;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Payload storage needs no reset: the top masks the head while it is not live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Live bits: purge clears every matching slot; a matching push on the same edge lands dead.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         live <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (id_match(purge, mem[i].id, purge_id)) begin
               live[i] <= 1'b0;
            end
         end
         if (push) begin
            live[wr_ptr] <= !id_match(purge, push_entry.id, purge_id);
         end
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Occupancy counts purged-but-not-yet-discarded slots too.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         occupancy <= '0;
      end else begin
         case ({push, pop})
            2'b10:   occupancy <= occupancy + OCC_ONE;
            2'b01:   occupancy <= occupancy - OCC_ONE;
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Head is read combinationally from the slot under the read pointer.
   always_comb begin
      head_entry = mem[rd_ptr];
      head_live  = live[rd_ptr];
   end

endmodule

// File: rtl/pipeline_drain.sv
// rtl/pipeline_drain.sv - pipeline tail receiver: buffering, global stall and flush origination
module pipeline_drain
   import pipeline_drain_pkg::*;
#(
   parameter  int DEPTH = DRAIN_DEPTH,
   localparam int PTR_W = $clog2(DEPTH)
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] in_address,
   input  logic [ID_W-1:0]   in_id,
   input  logic              in_valid,
   input  logic              ext_stall,
   input  logic              flush_req,
   input  logic [ID_W-1:0]   flush_req_id,
   output logic              stall_out,
   output logic              flush_out,
   output logic [ID_W-1:0]   flush_id_out,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [ADDR_W-1:0] rd_address,
   output logic [ID_W-1:0]   rd_id,
   output logic [PTR_W:0]    occupancy
);

   localparam logic [PTR_W:0] OCC_ONE  = {{PTR_W{1'b0}}, 1'b1};
   localparam logic [PTR_W:0] OCC_FULL = (PTR_W+1)'(DEPTH);

   logic           push;
   logic           pop;
   logic           nonempty;
   logic           head_live;
   entry_t         head_entry;
   entry_t         push_entry;
   logic [PTR_W:0] occupancy_next;

   drain_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .purge      (flush_req),
      .purge_id   (flush_req_id),
      .head_entry (head_entry),
      .head_live  (head_live),
      .occupancy  (occupancy)
   );

   // Push/pop decisions; a dead head is discarded silently, one per cycle.
   always_comb begin
      push_entry = '{address: in_address, id: in_id};
      push       = in_valid && !stall_out;
      nonempty   = (occupancy != '0);
      rd_valid   = nonempty && head_live;
      pop        = (rd_valid && rd_ready) || (nonempty && !head_live);
      rd_address = rd_valid ? head_entry.address : '0;
      rd_id      = rd_valid ? head_entry.id      : '0;
   end

   // Occupancy after this edge, used to raise stall before the buffer can overflow.
   always_comb begin
      occupancy_next = occupancy;
      case ({push, pop})
         2'b10:   occupancy_next = occupancy + OCC_ONE;
         2'b01:   occupancy_next = occupancy - OCC_ONE;
         default: occupancy_next = occupancy;
      endcase
   end

   // Global stall register: full next cycle or external hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_out <= 1'b0;
      end else begin
         stall_out <= (occupancy_next == OCC_FULL) || ext_stall;
      end
   end

   // Flush broadcast is a one-cycle registered copy of the request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flush_out    <= 1'b0;
         flush_id_out <= '0;
      end else begin
         flush_out    <= flush_req;
         flush_id_out <= flush_req_id;
      end
   end

endmodule

// File: tb/tb_pipeline_drain.sv
// tb/tb_pipeline_drain.sv - randomized self-checking bench for pipeline_drain against a queue model
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 16
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

module tb_pipeline_drain;

   localparam int DEPTH = 8;
   localparam int AW    = `ADDRESS_WIDTH;
   localparam int IW    = `ID_WIDTH;
   localparam int PW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] in_address;
   logic [IW-1:0] in_id;
   logic          in_valid;
   logic          ext_stall;
   logic          flush_req;
   logic [IW-1:0] flush_req_id;
   logic          stall_out;
   logic          flush_out;
   logic [IW-1:0] flush_id_out;
   logic          rd_valid;
   logic          rd_ready;
   logic [AW-1:0] rd_address;
   logic [IW-1:0] rd_id;
   logic [PW:0]   occupancy;

   always #5 clk = ~clk;

   pipeline_drain #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .in_address   (in_address),
      .in_id        (in_id),
      .in_valid     (in_valid),
      .ext_stall    (ext_stall),
      .flush_req    (flush_req),
      .flush_req_id (flush_req_id),
      .stall_out    (stall_out),
      .flush_out    (flush_out),
      .flush_id_out (flush_id_out),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_address   (rd_address),
      .rd_id        (rd_id),
      .occupancy    (occupancy)
   );

   typedef struct {
      logic [AW-1:0] a;
      logic [IW-1:0] id;
      bit            v;
   } ment_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [IW-1:0] id;
   } src_t;

   ment_t         mq[$];
   src_t          src[$];
   int            log_ids[$];
   bit            m_stall;
   bit            m_fl;
   logic [IW-1:0] m_flid;
   bit            gate = 1'b1;
   bit            check_en = 1'b0;
   int            errors = 0;
   int            checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_log(input string name, input int exp[$]);
      check({name, "_count"}, log_ids.size(), exp.size());
      for (int i = 0; i < exp.size() && i < log_ids.size(); i++) begin
         check($sformatf("%s_id%0d", name, i), log_ids[i], exp[i]);
      end
   endtask

   task automatic add_src(input int id);
      src_t s;
      s.a  = AW'($urandom);
      s.id = IW'(id);
      src.push_back(s);
   endtask

   task automatic model_clear();
      mq.delete();
      m_stall = 1'b0;
      m_fl    = 1'b0;
      m_flid  = '0;
   endtask

   // Behavioural meaning of one clock edge, expressed on a queue of entries.
   task automatic model_edge();
      bit   push;
      bit   pop;
      ment_t e;
      if (!reset_n) begin
         model_clear();
         return;
      end
      push = !m_stall && in_valid;
      pop  = (mq.size() > 0) && (!mq[0].v || rd_ready);
      if (pop) begin
         if (mq[0].v) log_ids.push_back(int'(mq[0].id));
         void'(mq.pop_front());
      end
      if (flush_req) begin
         foreach (mq[i]) if (mq[i].id == flush_req_id) mq[i].v = 1'b0;
      end
      if (push) begin
         e.a  = in_address;
         e.id = in_id;
         e.v  = !(flush_req && in_id == flush_req_id);
         mq.push_back(e);
         void'(src.pop_front());
      end
      m_stall = (mq.size() == DEPTH) || ext_stall;
      m_fl    = flush_req;
      m_flid  = flush_req_id;
   endtask

   task automatic drive();
      if (src.size() > 0 && gate) begin
         in_valid   = 1'b1;
         in_id      = src[0].id;
         in_address = src[0].a;
      end else begin
         in_valid   = 1'b0;
         in_id      = '0;
         in_address = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
      drive();
   endtask

   task automatic drain(input string name, input int maxc);
      int n;
      n = 0;
      rd_ready = 1'b1;
      gate = 1'b1;
      while ((mq.size() > 0 || src.size() > 0) && n < maxc) begin
         tick();
         n++;
      end
      check({name, "_drained"}, 32'(mq.size() == 0 && src.size() == 0), 32'd1);
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic          ev;
      logic [AW-1:0] ea;
      logic [IW-1:0] ei;
      if (check_en) begin
         ev = (mq.size() > 0) && mq[0].v;
         ea = ev ? mq[0].a  : '0;
         ei = ev ? mq[0].id : '0;
         check("rd_valid",     32'(rd_valid),     32'(ev));
         check("rd_address",   32'(rd_address),   32'(ea));
         check("rd_id",        32'(rd_id),        32'(ei));
         check("occupancy",    32'(occupancy),    32'(mq.size()));
         check("stall_out",    32'(stall_out),    32'(m_stall));
         check("flush_out",    32'(flush_out),    32'(m_fl));
         check("flush_id_out", 32'(flush_id_out), 32'(m_flid));
      end
   end

   initial begin
      int exp_ids[$];
      int cnt;
      int min_occ;

      reset_n = 1'b0; in_address = '0; in_id = '0; in_valid = 1'b0;
      ext_stall = 1'b0; flush_req = 1'b0; flush_req_id = '0; rd_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("reset_rd_valid",  32'(rd_valid),  32'd0);
      check("reset_occupancy", 32'(occupancy), 32'd0);
      check("reset_stall",     32'(stall_out), 32'd0);
      check("reset_flush",     32'(flush_out), 32'd0);
      reset_n = 1'b1;
      check_en = 1'b1;

      // Fill past capacity with the consumer blocked.
      for (int i = 1; i <= 10; i++) add_src(i);
      rd_ready = 1'b0;
      drive();
      repeat (12) tick();
      check("fill_occupancy", 32'(occupancy), 32'd8);
      check("fill_stall",     32'(stall_out), 32'd1);
      check("fill_model_occ", 32'(mq.size()), 32'd8);
      check("fill_src_left",  32'(src.size()), 32'd2);
      log_ids.delete();
      drain("fill", 60);
      exp_ids.delete();
      for (int i = 1; i <= 10; i++) exp_ids.push_back(i);
      check_log("fill_order", exp_ids);

      // Full buffer with a continuously ready consumer.
      log_ids.delete();
      exp_ids.delete();
      for (int i = 0; i < 24; i++) begin
         add_src(i % 16);
         exp_ids.push_back(i % 16);
      end
      rd_ready = 1'b0;
      drive();
      repeat (10) tick();
      rd_ready = 1'b1;
      min_occ = DEPTH;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (int'(occupancy) < min_occ) min_occ = int'(occupancy);
      end
      check("thru_min_occ_ge7", 32'(min_occ >= 7), 32'd1);
      drain("thru", 100);
      check_log("thru_order", exp_ids);

      // Purge of buffered matching ids.
      log_ids.delete();
      add_src(3); add_src(5); add_src(3); add_src(7);
      rd_ready = 1'b0;
      drive();
      repeat (6) tick();
      flush_req = 1'b1;
      flush_req_id = 4'(3);
      tick();
      flush_req = 1'b0;
      check("flush_pulse",   32'(flush_out),    32'd1);
      check("flush_id",      32'(flush_id_out), 32'd3);
      tick();
      check("flush_one_cyc", 32'(flush_out),    32'd0);
      drain("flush", 40);
      exp_ids.delete();
      exp_ids.push_back(5); exp_ids.push_back(7);
      check_log("flush_seen", exp_ids);
      check("flush_occ_zero", 32'(occupancy), 32'd0);

      // Flush on the very edge that pushes the matching id.
      log_ids.delete();
      rd_ready = 1'b1;
      add_src(4);
      drive();
      flush_req = 1'b1;
      flush_req_id = 4'(4);
      tick();
      flush_req = 1'b0;
      drain("same_edge", 20);
      exp_ids.delete();
      check_log("same_edge_seen", exp_ids);

      // External stall for three cycles.
      log_ids.delete();
      rd_ready = 1'b0;
      for (int i = 0; i < 6; i++) add_src(8 + i);
      drive();
      ext_stall = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 2) ext_stall = 1'b0;
         if (stall_out) cnt++;
      end
      check("ext_stall_cycles", 32'(cnt),       32'd3);
      check("ext_stall_occ",    32'(occupancy), 32'd3);
      drain("ext", 40);

      // Randomized traffic with frequent id collisions.
      for (int c = 0; c < 800; c++) begin
         if (src.size() < 4) add_src(int'($urandom_range(0, 3)));
         rd_ready     = ($urandom % 4) != 0;
         ext_stall    = ($urandom % 8) == 0;
         flush_req    = ($urandom % 6) == 0;
         flush_req_id = IW'($urandom_range(0, 3));
         gate         = ($urandom % 4) != 0;
         drive();
         tick();
      end
      ext_stall = 1'b0;
      flush_req = 1'b0;
      drain("random", 200);

      // Asynchronous reset with entries buffered and stall raised.
      rd_ready = 1'b0;
      for (int i = 0; i < 5; i++) add_src(i + 1);
      drive();
      repeat (7) tick();
      check("prereset_occ", 32'(occupancy), 32'd5);
      ext_stall = 1'b1;
      tick();
      check("prereset_stall", 32'(stall_out), 32'd1);
      reset_n = 1'b0;
      ext_stall = 1'b0;
      src.delete();
      drive();
      #1;
      model_clear();
      check("async_rd_valid", 32'(rd_valid),   32'd0);
      check("async_occ",      32'(occupancy),  32'd0);
      check("async_stall",    32'(stall_out),  32'd0);
      check("async_rd_id",    32'(rd_id),      32'd0);
      check("async_rd_addr",  32'(rd_address), 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (3) tick();
      check("post_reset_valid", 32'(rd_valid),  32'd0);
      check("post_reset_occ",   32'(occupancy), 32'd0);

      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_drain.md
Name: pipeline_drain

Overview:
- Tail-end receiver for the global-stall pipeline. Consumes the last stage's address/id/valid outputs and buffers them in a DEPTH-entry FIFO for a ready/valid consumer.
- Owns the global stall: drives the stall seen by every stage, asserting it when the FIFO would overflow or on external request.
- Originates the flush broadcast into the first stage. Purges matching ids already buffered in the FIFO.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_address  input  `ADDRESS_WIDTH  last stage out_address.
- in_id  input  `ID_WIDTH  last stage out_id.
- in_valid  input  1  last stage out_valid.
- ext_stall  input  1  external stall request (e.g. debug/host).
- flush_req  input  1  one-cycle request to flush an id.
- flush_req_id  input  `ID_WIDTH  id to flush.
- stall_out  output  1  global stall to all stages (in_stall).
- flush_out  output  1  flush broadcast to first stage (in_flush).
- flush_id_out  output  `ID_WIDTH  flush id broadcast (in_flush_id).
- rd_valid  output  1  head entry valid for consumer.
- rd_ready  input  1  consumer accepts head.
- rd_address  output  `ADDRESS_WIDTH  head entry address.
- rd_id  output  `ID_WIDTH  head entry id.
- occupancy  output  PTR_W+1  entries currently stored, including purged-but-not-popped entries.

Behaviour:
- Reset values (async, while reset_n=0): stall_out=0, flush_out=0, flush_id_out=0, pointers=0, occupancy=0, all entry-valid bits=0, rd_valid=0. rd_address and rd_id read 0 while empty.
- Capture rule: on a rising edge where stall_out=0 and in_valid=1, push {in_address, in_id} with entry-valid=1.
  - No push when stall_out=1: the stages hold on that edge, so the held value is neither duplicated nor lost.
- stall_out is registered: stall_out_next = (occupancy_next == DEPTH) | ext_stall.
  - Stall is therefore high on any edge where occupancy==DEPTH, so the FIFO never overflows.
  - All DEPTH entries are usable.
  - ext_stall takes effect one cycle after it is asserted.
- Pop rule: pop the head when (rd_valid & rd_ready), or when (occupancy != 0 & head entry-valid == 0). The second case is a silent discard, at most one per cycle.
- Read outputs:
  - rd_valid = (occupancy != 0) & head entry-valid.
  - rd_address and rd_id are read combinationally from head storage. They are zero when rd_valid=0.
- Occupancy: occupancy_next = occupancy + push - pop.
  - Simultaneous push and pop at full or empty is legal; push at empty with no pop in the same cycle.
  - Pointers wrap modulo DEPTH.
- Flush:
  - flush_out and flush_id_out are registered copies of flush_req and flush_req_id: exactly one cycle of latency, one-cycle pulse per request. Back-to-back requests give back-to-back pulses.
  - On the edge where flush_req=1, every stored entry with id == flush_req_id has entry-valid cleared.
  - An entry pushed on that same edge with a matching id is stored with entry-valid=0.
  - A head entry popped by the consumer on that edge is unaffected; it was already consumed.
- Arithmetic: no arithmetic on address or id; both pass through unmodified.
- Reset mid-operation: all buffered entries are discarded immediately and stall_out deasserts. The upstream pipeline is reset by the same net.

Decomposition:
- Widths come from `ADDRESS_WIDTH and `ID_WIDTH in defines.vh.
- Add to defines.vh: `DRAIN_DEPTH default 8.
- One sub-module: drain_fifo.
  - Storage, pointers, occupancy, per-entry valid bits, and the id-match purge.
  - pipeline_drain keeps the stall register, flush register and push/pop decisions.

Test Plan:
- DEPTH=8, rd_ready=0, in_valid=1 with ids 1..10 → exactly ids 1..8 stored. stall_out=1 from the cycle after the 8th push; occupancy=8. Release rd_ready=1 → rd_id sequence 1..8, then 9, 10 with no duplicates.
- Full FIFO, rd_ready=1 continuously, in_valid=1 → one push and one pop per cycle. occupancy stays 8, or toggles 7/8 with the stall cycle; no entry lost.
- Store ids 3,5,3,7; pulse flush_req, flush_req_id=3 → flush_out=1, flush_id_out=3 for exactly one cycle, one cycle later. Consumer sees ids 5, 7 only; occupancy drains to 0.
- flush_req, flush_req_id=4 on the same edge that pushes id 4 → entry is never presented and is discarded silently.
- ext_stall=1 for 3 cycles with in_valid=1 → stall_out high for 3 cycles, lagging by 1; no pushes on stalled edges.
- Reset_n low mid-transfer with 5 entries stored → outputs go to reset values immediately without a clock. After release, empty FIFO, rd_valid=0.
